mealy_step_seq: RTL and testbench

//  Clocked, parametrised N-state Mealy step sequencer. Each qualified rising edge of

---
 rtl/mealy_step_seq.sv | 188 ++++++++++++++++++
 tb/tb_mealy_step_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mealy_step_seq.sv
// -----------------------------------------------------------------------------
// mealy_step_seq
//   N-state Mealy step sequencer. An asynchronous step input is synchronised
//   (and optionally debounced). Each qualified low->high transition of the
//   filtered input, taken while en_i is high, advances a modulo-NSTATES state
//   counter. While the filtered input is high, y_o shows the current state as
//   a one-hot code.
//
// Parameters
//   NSTATES      number of states (>=2); the state wraps NSTATES-1 -> 0
//   SYNC_STAGES  synchroniser flops on x_i (>=2)
//   DEB_CYCLES   stable clocks needed to accept a level change (debounce only)
//
// Build option
//   MEALY_STEP_DEBOUNCE_EN  when defined, a DEB_CYCLES debounce filter sits
//                           between the synchroniser and the edge detector.
//                           When undefined, the filtered level is the
//                           synchronised level and DEB_CYCLES is unused.
//
// Ports
//   clk_i    system clock, all flops rising-edge
//   rstn_i   asynchronous active-low reset
//   en_i     step enable, sampled on the clock of the detected edge
//   x_i      asynchronous step input
//   y_o      one-hot Mealy output: y_o[NSTATES-1-state] = filtered x
//   state_o  current state (registered)
//   step_o   one-clock pulse: the state advanced
//   wrap_o   one-clock pulse: the advance was NSTATES-1 -> 0
// -----------------------------------------------------------------------------
module mealy_step_seq #(
  parameter int NSTATES     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  localparam int SW = ($clog2(NSTATES) > 1) ? $clog2(NSTATES) : 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic               x_i,
  output logic [NSTATES-1:0] y_o,
  output logic [SW-1:0]      state_o,
  output logic               step_o,
  output logic               wrap_o
);

  localparam logic [SW-1:0] LAST_STATE = SW'(NSTATES - 1);

  // Illegal parameter sets elaborate nothing extra; the block only names them.
  if ((NSTATES < 2) || (SYNC_STAGES < 2) || (DEB_CYCLES < 1)) begin : g_bad_params
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   xs_s;
  logic                   xf_s;
  logic                   xf_dly_q;
  logic                   armed_q;
  logic                   armed_d;
  logic                   rise_s;
  logic [SW-1:0]          state_q;
  logic [SW-1:0]          state_d;
  logic                   step_q;
  logic                   step_d;
  logic                   wrap_q;
  logic                   wrap_d;
  logic [NSTATES-1:0]     y_s;

  // Synchroniser chain on x_i, plus a shadow chain that marks when the
  // synchroniser holds a real sample of x_i rather than reset zeros.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], x_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign xs_s = sync_q[SYNC_STAGES-1];

`ifdef MEALY_STEP_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [DW-1:0] deb_cnt_q;
  logic [DW-1:0] deb_cnt_d;
  logic          xf_q;
  logic          xf_d;

  // Debounce next state: the filtered level follows xs_s only after
  // DEB_CYCLES consecutive clocks of disagreement; any agreement restarts.
  always_comb begin
    deb_cnt_d = '0;
    xf_d      = xf_q;
    if (xs_s != xf_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        xf_d      = xs_s;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Debounce registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      deb_cnt_q <= '0;
      xf_q      <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      xf_q      <= xf_d;
    end
  end

  assign xf_s = xf_q;
`else
  assign xf_s = xs_s;
`endif

  // The edge detector arms only once a genuine low level of x has propagated
  // through the whole filter after reset. If x is held high across a reset,
  // the synchroniser refilling with ones is therefore not taken as an edge;
  // x must go low and high again.
  assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~xs_s & ~xf_s);
  assign rise_s  = xf_s & ~xf_dly_q & armed_q;

  // State register: sequencer state, pulses, edge history and arming flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      xf_dly_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      xf_dly_q <= xf_s;
      armed_q  <= armed_d;
    end
  end

  // Next-state logic: an enabled edge advances modulo NSTATES. An
  // out-of-range state also reloads 0 on its next advance, without wrap.
  // An edge seen with en_i low is dropped, not remembered.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (rise_s && en_i) begin
      step_d = 1'b1;
      if (state_q >= LAST_STATE) begin
        state_d = '0;
        wrap_d  = (state_q == LAST_STATE);
      end else begin
        state_d = state_q + SW'(1);
        wrap_d  = 1'b0;
      end
    end else begin
      state_d = state_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  // Output logic: Mealy decode from the registered filtered level and the
  // state. An out-of-range state matches no bit, so y stays 0.
  always_comb begin
    y_s = '0;
    for (int i = 0; i < NSTATES; i++) begin
      if (xf_s && (state_q == SW'(NSTATES - 1 - i))) begin
        y_s[i] = 1'b1;
      end else begin
        y_s[i] = 1'b0;
      end
    end
  end

  assign y_o     = y_s;
  assign state_o = state_q;
  assign step_o  = step_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_mealy_step_seq.sv
module tb_mealy_step_seq;

  localparam int NSTATES     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 4;
`ifdef MEALY_STEP_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + DEB_CYCLES;
`else
  localparam int LAT = SYNC_STAGES;
`endif
  localparam int HOLD = LAT + 4;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic       en   = 1'b0;
  logic       x    = 1'b0;
  logic [2:0] y;
  logic [1:0] state;
  logic       step;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mealy_step_seq #(
    .NSTATES    (NSTATES),
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .en_i   (en),
    .x_i    (x),
    .y_o    (y),
    .state_o(state),
    .step_o (step),
    .wrap_o (wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One x pulse: HOLD clocks high then HOLD clocks low, with hand-computed
  // expected state and outputs before and after the (possible) advance.
  task automatic x_pulse(input string tag, input logic [1:0] pre, input logic [1:0] post,
                         input logic [2:0] y_pre, input logic [2:0] y_post,
                         input logic exp_step, input logic exp_wrap);
    x = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      tick();
      check({tag, ".y_before_rise"}, y, 3'b000);
      check({tag, ".step_before_rise"}, step, 1'b0);
    end
    tick();
    check({tag, ".y_rise"}, y, y_pre);
    check({tag, ".state_rise"}, state, pre);
    check({tag, ".step_rise"}, step, 1'b0);
    tick();
    check({tag, ".state_adv"}, state, post);
    check({tag, ".step_adv"}, step, exp_step);
    check({tag, ".wrap_adv"}, wrap, exp_wrap);
    check({tag, ".y_adv"}, y, y_post);
    tick();
    check({tag, ".step_off"}, step, 1'b0);
    check({tag, ".wrap_off"}, wrap, 1'b0);
    repeat (HOLD - LAT - 2) tick();
    check({tag, ".y_hold"}, y, y_post);
    x = 1'b0;
    repeat (LAT - 1) tick();
    check({tag, ".y_before_fall"}, y, y_post);
    tick();
    check({tag, ".y_fall"}, y, 3'b000);
    check({tag, ".state_fall"}, state, post);
    repeat (HOLD - LAT) tick();
    check({tag, ".step_low"}, step, 1'b0);
    check({tag, ".state_low"}, state, post);
  endtask

  initial begin
    int nstep;

    // 1: reset with x high, then release with x low
    x = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check("t1.y_async", y, 3'b000);
    check("t1.state_async", state, 2'd0);
    check("t1.step_async", step, 1'b0);
    check("t1.wrap_async", wrap, 1'b0);
    repeat (4) tick();
    check("t1.y_held", y, 3'b000);
    x = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (LAT + 3) tick();
    check("t1.y_rel", y, 3'b000);
    check("t1.state_rel", state, 2'd0);
    check("t1.step_rel", step, 1'b0);
    check("t1.wrap_rel", wrap, 1'b0);

    // 2 and 3: four enabled pulses, states 1,2,0,1, one wrap
    en = 1'b1;
    x_pulse("t2.p1", 2'd0, 2'd1, 3'b100, 3'b010, 1'b1, 1'b0);
    x_pulse("t2.p2", 2'd1, 2'd2, 3'b010, 3'b001, 1'b1, 1'b0);
    x_pulse("t2.p3", 2'd2, 2'd0, 3'b001, 3'b100, 1'b1, 1'b1);
    x_pulse("t3.p4", 2'd0, 2'd1, 3'b100, 3'b010, 1'b1, 1'b0);

    // 4: disabled pulse, then enable raised while x still high
    en = 1'b0;
    x_pulse("t4.dis", 2'd1, 2'd1, 3'b010, 3'b010, 1'b0, 1'b0);
    x = 1'b1;
    repeat (LAT + 1) tick();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4.late_en_step", step, 1'b0);
      check("t4.late_en_state", state, 2'd1);
    end
    check("t4.late_en_y", y, 3'b010);
    x = 1'b0;
    repeat (HOLD) tick();
    check("t4.state_end", state, 2'd1);

    // 5: reset mid-operation at state 2 with x high
    x = 1'b1;
    repeat (LAT) tick();
    check("t5.y_rise", y, 3'b010);
    tick();
    check("t5.state_adv", state, 2'd2);
    check("t5.step_adv", step, 1'b1);
    tick();
    check("t5.y_pre_rst", y, 3'b001);
    rstn = 1'b0;
    #1;
    check("t5.y_async", y, 3'b000);
    check("t5.state_async", state, 2'd0);
    check("t5.step_async", step, 1'b0);
    check("t5.wrap_async", wrap, 1'b0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      check("t5.no_step_after_rel", step, 1'b0);
    end
    check("t5.state_after_rel", state, 2'd0);
    check("t5.y_after_rel", y, 3'b100);
    x = 1'b0;
    repeat (LAT + 2) tick();
    check("t5.y_low", y, 3'b000);
    check("t5.state_low", state, 2'd0);
    x_pulse("t5.rearm", 2'd0, 2'd1, 3'b100, 3'b010, 1'b1, 1'b0);

`ifdef MEALY_STEP_DEBOUNCE_EN
    // 6: debounce glitch rejection and latency of an accepted pulse
    x = 1'b1;
    repeat (2) tick();
    x = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("t6.glitch_step", step, 1'b0);
      check("t6.glitch_y", y, 3'b000);
    end
    check("t6.glitch_state", state, 2'd1);
    nstep = 0;
    x = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step) nstep++;
      check("t6.step_timing", step, (i == 7) ? 1'b1 : 1'b0);
    end
    x = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (step) nstep++;
    end
    check("t6.step_count", nstep, 1);
    check("t6.state_end", state, 2'd2);
`else
    nstep = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
